// File: rtl/ft_pkg.sv
// Shared fault-tolerance definitions: recovery FSM state encoding and default parameters
// used by the recovery controller, the comparator and the checkpoint unit.
package ft_pkg;

    typedef enum logic [2:0] {
        FT_IDLE      = 3'd0,
        FT_RESET     = 3'd1,
        FT_RECOVER   = 3'd2,
        FT_WAIT_DONE = 3'd3,
        FT_FATAL     = 3'd4
    } ft_state_e;

    localparam int unsigned FT_NCORES          = 3;
    localparam int unsigned FT_RECOVERY_CYCLES = 4;
    localparam int unsigned FT_TIMEOUT_CYCLES  = 64;
    localparam int unsigned FT_GUARD_CYCLES    = 16;
    localparam int unsigned FT_MAX_RETRIES     = 3;

    function automatic int unsigned ft_max3(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ft_recovery_ctrl.sv
// Recovery controller for N redundant cores: latches the faulty-core vector, sequences
// core reset / state recovery / completion wait, and escalates to a sticky FATAL state.
module ft_recovery_ctrl
    import ft_pkg::*;
#(
    parameter int unsigned NCORES          = FT_NCORES,
    parameter int unsigned RECOVERY_CYCLES = FT_RECOVERY_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES  = FT_TIMEOUT_CYCLES,
    parameter int unsigned GUARD_CYCLES    = FT_GUARD_CYCLES,
    parameter int unsigned MAX_RETRIES     = FT_MAX_RETRIES
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               enable_i,
    input  logic [NCORES-1:0]                  error_i,
    input  logic                               force_error_i,
    input  logic                               recovery_done_i,
    input  logic                               clear_fatal_i,
    output logic [NCORES-1:0]                  core_rst_no,
    output logic                               recover_o,
    output logic                               recovering_o,
    output logic                               load_pc_o,
    output logic [NCORES-1:0]                  faulty_core_o,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt_o,
    output logic                               fatal_o
);

    localparam int unsigned CNT_W = $clog2(ft_max3(RECOVERY_CYCLES, TIMEOUT_CYCLES,
                                                   GUARD_CYCLES) + 1);
    localparam int unsigned RTY_W = $clog2(MAX_RETRIES + 1);

    ft_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [NCORES-1:0] faulty_q, faulty_d;
    logic              in_window;

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= FT_IDLE;
            cnt_q    <= '0;
            retry_q  <= '0;
            faulty_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            faulty_q <= faulty_d;
        end
    end

    // The shared counter holds the guard window while in IDLE; checked before decrement
    assign in_window = (cnt_q != '0);

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        faulty_d = faulty_q;
        if (enable_i) begin
            case (state_q)
                FT_IDLE: begin
                    if ((|error_i) || force_error_i) begin
                        faulty_d = error_i;
                        cnt_d    = '0;
                        if (in_window && (retry_q == RTY_W'(MAX_RETRIES))) begin
                            state_d = FT_FATAL;
                        end else begin
                            retry_d = in_window ? (retry_q + RTY_W'(1)) : RTY_W'(1);
                            state_d = FT_RESET;
                        end
                    end else begin
                        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_d == '0) retry_d = '0;
                    end
                end
                FT_RESET: begin
                    state_d = FT_RECOVER;
                    cnt_d   = CNT_W'(RECOVERY_CYCLES - 1);
                end
                FT_RECOVER: begin
                    if (cnt_q == '0) begin
                        state_d = FT_WAIT_DONE;
                        cnt_d   = CNT_W'(TIMEOUT_CYCLES - 1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                FT_WAIT_DONE: begin
                    if (recovery_done_i) begin
                        state_d = FT_IDLE;
                        cnt_d   = CNT_W'(GUARD_CYCLES);
                    end else if (cnt_q == '0) begin
                        state_d = FT_FATAL;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                FT_FATAL: begin
                    if (clear_fatal_i) begin
                        state_d  = FT_IDLE;
                        cnt_d    = '0;
                        retry_d  = '0;
                        faulty_d = '0;
                    end
                end
                default: begin
                    state_d = FT_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Moore output decode
    always_comb begin
        core_rst_no   = '1;
        recover_o     = 1'b0;
        recovering_o  = 1'b0;
        load_pc_o     = 1'b0;
        fatal_o       = 1'b0;
        faulty_core_o = faulty_q;
        retry_cnt_o   = retry_q;
        case (state_q)
            FT_IDLE:      load_pc_o = 1'b1;
            FT_RESET: begin
                core_rst_no = '0;
                load_pc_o   = 1'b1;
            end
            FT_RECOVER: begin
                recover_o    = 1'b1;
                recovering_o = 1'b1;
            end
            FT_WAIT_DONE: recovering_o = 1'b1;
            FT_FATAL: begin
                core_rst_no = '0;
                fatal_o     = 1'b1;
            end
            default:      load_pc_o = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Directed bench for ft_recovery_ctrl: phase-level reference model checked every cycle,
// plus literal expectations along the test-plan scenarios.
module tb_ft_recovery_ctrl;

    localparam int NC   = 3;
    localparam int RC   = 4;
    localparam int TO   = 64;
    localparam int GD   = 16;
    localparam int MAXR = 3;
    localparam int RW   = $clog2(MAXR + 1);

    localparam int P_IDLE = 0, P_RESET = 1, P_RECOVER = 2, P_WAIT = 3, P_FATAL = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          enable_i = 1'b1;
    logic [NC-1:0] error_i = '0;
    logic          force_error_i = 1'b0;
    logic          recovery_done_i = 1'b0;
    logic          clear_fatal_i = 1'b0;
    logic [NC-1:0] core_rst_no;
    logic          recover_o;
    logic          recovering_o;
    logic          load_pc_o;
    logic [NC-1:0] faulty_core_o;
    logic [RW-1:0] retry_cnt_o;
    logic          fatal_o;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    ft_recovery_ctrl #(
        .NCORES(NC), .RECOVERY_CYCLES(RC), .TIMEOUT_CYCLES(TO),
        .GUARD_CYCLES(GD), .MAX_RETRIES(MAXR)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .error_i(error_i),
        .force_error_i(force_error_i), .recovery_done_i(recovery_done_i),
        .clear_fatal_i(clear_fatal_i), .core_rst_no(core_rst_no), .recover_o(recover_o),
        .recovering_o(recovering_o), .load_pc_o(load_pc_o), .faulty_core_o(faulty_core_o),
        .retry_cnt_o(retry_cnt_o), .fatal_o(fatal_o)
    );

    always #5 clk_i = ~clk_i;

    // Model: phase, cycles spent in phase, cycles since last return to IDLE
    typedef struct {
        int            phase;
        int            cyc;
        int            since;
        int            retry;
        logic [NC-1:0] faulty;
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m.phase = P_IDLE; m.cyc = 0; m.since = GD; m.retry = 0; m.faulty = '0;
        return m;
    endfunction

    function automatic model_t model_step(input model_t cur, input logic [NC-1:0] err,
                                          input logic frc, input logic done, input logic clr);
        model_t m;
        m = cur;
        case (cur.phase)
            P_IDLE: begin
                if (err != '0 || frc) begin
                    m.faulty = err;
                    if (cur.since < GD && cur.retry == MAXR) m.phase = P_FATAL;
                    else begin
                        m.retry = (cur.since < GD) ? cur.retry + 1 : 1;
                        m.phase = P_RESET;
                    end
                end else if (cur.since < GD) begin
                    m.since = cur.since + 1;
                    if (m.since == GD) m.retry = 0;
                end
            end
            P_RESET: begin m.phase = P_RECOVER; m.cyc = 0; end
            P_RECOVER: begin
                m.cyc = cur.cyc + 1;
                if (m.cyc == RC) begin m.phase = P_WAIT; m.cyc = 0; end
            end
            P_WAIT: begin
                if (done) begin m.phase = P_IDLE; m.since = 0; end
                else begin
                    m.cyc = cur.cyc + 1;
                    if (m.cyc == TO) m.phase = P_FATAL;
                end
            end
            default: begin
                if (clr) begin
                    m.phase = P_IDLE; m.retry = 0; m.faulty = '0; m.since = GD;
                end
            end
        endcase
        return m;
    endfunction

    model_t mdl = model_reset();

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) mdl <= model_reset();
        else if (enable_i)
            mdl <= model_step(mdl, error_i, force_error_i, recovery_done_i, clear_fatal_i);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("m_core_rst", 32'(core_rst_no),
                  (mdl.phase == P_RESET || mdl.phase == P_FATAL) ? 32'h0 : 32'h7);
            check("m_recover", 32'(recover_o), 32'(mdl.phase == P_RECOVER));
            check("m_recovering", 32'(recovering_o),
                  32'(mdl.phase == P_RECOVER || mdl.phase == P_WAIT));
            check("m_load_pc", 32'(load_pc_o),
                  32'(mdl.phase == P_IDLE || mdl.phase == P_RESET));
            check("m_fatal", 32'(fatal_o), 32'(mdl.phase == P_FATAL));
            check("m_faulty", 32'(faulty_core_o), 32'(mdl.faulty));
            check("m_retry", 32'(retry_cnt_o), 32'(mdl.retry));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_i);
    endtask

    // Inject an error in IDLE and walk through RESET/RECOVER into WAIT_DONE
    task automatic run_fault(input logic [NC-1:0] err, input logic frc, input bit give_done);
        int c;
        error_i = err; force_error_i = frc;
        tick();
        error_i = '0; force_error_i = 1'b0;
        check("rst_pulse", 32'(core_rst_no), 32'h0);
        check("load_pc_in_reset", 32'(load_pc_o), 32'h1);
        c = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (recover_o) c++;
            else break;
        end
        check("recover_len", 32'(c), 32'(RC));
        check("in_wait_done", 32'(recovering_o), 32'h1);
        if (give_done) begin
            recovery_done_i = 1'b1;
            tick();
            recovery_done_i = 1'b0;
            check("back_idle", 32'(load_pc_o && !recovering_o), 32'h1);
        end
    endtask

    initial begin
        int c;
        tick(3);
        check("rst_core_rst", 32'(core_rst_no), 32'h7);
        check("rst_load_pc", 32'(load_pc_o), 32'h1);
        check("rst_recovering", 32'(recovering_o), 32'h0);
        check("rst_retry", 32'(retry_cnt_o), 32'h0);
        rst_ni = 1'b1;
        chk_en = 1'b1;
        tick(2);

        // Single fault on core 1
        run_fault(3'b010, 1'b0, 1'b1);
        check("single_faulty", 32'(faulty_core_o), 32'h2);
        check("single_retry", 32'(retry_cnt_o), 32'h1);

        // Back-to-back errors inside the guard window escalate
        tick(5);
        run_fault(3'b001, 1'b0, 1'b1);
        check("esc_retry2", 32'(retry_cnt_o), 32'h2);
        tick(5);
        run_fault(3'b011, 1'b0, 1'b1);
        check("esc_retry3", 32'(retry_cnt_o), 32'h3);
        tick(5);
        error_i = 3'b100;
        tick();
        error_i = '0;
        check("esc_fatal", 32'(fatal_o), 32'h1);
        check("esc_core_rst", 32'(core_rst_no), 32'h0);
        check("esc_load_pc", 32'(load_pc_o), 32'h0);
        check("esc_faulty", 32'(faulty_core_o), 32'h4);
        tick(4);
        check("fatal_sticky", 32'(fatal_o), 32'h1);
        clear_fatal_i = 1'b1;
        tick();
        clear_fatal_i = 1'b0;
        check("clear_fatal", 32'(fatal_o), 32'h0);
        check("clear_retry", 32'(retry_cnt_o), 32'h0);
        check("clear_faulty", 32'(faulty_core_o), 32'h0);
        tick(2);

        // Guard expiry: second error 20 cycles after IDLE restarts the count
        run_fault(3'b010, 1'b0, 1'b1);
        check("guard_first", 32'(retry_cnt_o), 32'h1);
        tick(20);
        check("guard_expired", 32'(retry_cnt_o), 32'h0);
        run_fault(3'b001, 1'b0, 1'b1);
        check("guard_retry1", 32'(retry_cnt_o), 32'h1);
        tick(20);

        // Timeout in WAIT_DONE
        run_fault(3'b100, 1'b0, 1'b0);
        c = 0;
        for (int i = 0; i < 200; i++) begin
            if (fatal_o) break;
            if (recovering_o && !recover_o) c++;
            tick();
        end
        check("timeout_fatal", 32'(fatal_o), 32'h1);
        check("timeout_len", 32'(c), 32'(TO));
        clear_fatal_i = 1'b1;
        tick();
        clear_fatal_i = 1'b0;
        tick(2);

        // Freeze mid-RECOVER, then asynchronous reset mid-WAIT_DONE
        error_i = 3'b001;
        tick();
        error_i = '0;
        c = 0;
        tick(); if (recover_o) c++;
        tick(); if (recover_o) c++;
        enable_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("freeze_recover", 32'(recover_o), 32'h1);
        end
        enable_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (recover_o) c++;
            else break;
        end
        check("freeze_len", 32'(c), 32'(RC));
        check("freeze_wait", 32'(recovering_o), 32'h1);
        tick(3);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_core_rst", 32'(core_rst_no), 32'h7);
        check("arst_recovering", 32'(recovering_o), 32'h0);
        check("arst_load_pc", 32'(load_pc_o), 32'h1);
        check("arst_faulty", 32'(faulty_core_o), 32'h0);
        check("arst_retry", 32'(retry_cnt_o), 32'h0);
        check("arst_fatal", 32'(fatal_o), 32'h0);
        tick();
        rst_ni = 1'b1;
        tick(2);

        // Software-forced error has no culprit
        run_fault(3'b000, 1'b1, 1'b1);
        check("force_faulty", 32'(faulty_core_o), 32'h0);
        check("force_retry", 32'(retry_cnt_o), 32'h1);
        tick(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ft_recovery_ctrl.md
# ft_recovery_ctrl

Parametrised fault-tolerance recovery controller for N redundant cores. It latches per-core error flags and drives a core reset pulse, a fixed-length state-recovery phase and a wait for recovery completion. It counts back-to-back recovery attempts and escalates to a sticky fatal state after too many retries or a recovery timeout. It sits between the lockstep/TMR comparator and the cores, checkpoint and PC logic of the FT module.

## Interface
- NCORES, 3: number of redundant cores (≥2).
- RECOVERY_CYCLES, 4: cycles spent in RECOVER (≥1).
- TIMEOUT_CYCLES, 64: maximum cycles in WAIT_DONE before escalation (≥1).
- GUARD_CYCLES, 16: window after returning to IDLE in which a new error counts as a retry (≥1).
- MAX_RETRIES, 3: retries tolerated before FATAL (≥1).
- CNT_W, $clog2(max(RECOVERY_CYCLES, TIMEOUT_CYCLES, GUARD_CYCLES)+1): width of the shared cycle counter (derived).
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- enable_i  in  1  0 freezes state and counters; outputs hold.
- error_i  in  NCORES  per-core mismatch flags from the comparator.
- force_error_i  in  1  software/debug-injected error; treated as error with no culprit.
- recovery_done_i  in  1  checkpoint restore complete.
- clear_fatal_i  in  1  leaves FATAL and returns to IDLE.
- core_rst_no  out  NCORES  active-low core reset.
- recover_o  out  1  high in RECOVER.
- recovering_o  out  1  high in RECOVER or WAIT_DONE.
- load_pc_o  out  1  high in IDLE or RESET; PC checkpoint may be captured.
- faulty_core_o  out  NCORES  error vector latched at detection.
- retry_cnt_o  out  $clog2(MAX_RETRIES+1)  current retry count.
- fatal_o  out  1  high in FATAL.

## Operation
- States: IDLE, RESET, RECOVER, WAIT_DONE, FATAL.
- All outputs are Moore-decoded from registered state and registers; no input-to-output combinational path.
- IDLE: if enable_i && (|error_i || force_error_i):
  - latch faulty_core_o <= error_i;
  - if the guard counter is nonzero (inside the window) and retry_cnt == MAX_RETRIES, go to FATAL;
  - otherwise, inside the window, retry_cnt++; outside it, retry_cnt <= 1;
  - go to RESET.
- IDLE with no error: the guard counter decrements to 0, saturating. When it reaches 0, retry_cnt clears to 0.
- RESET: lasts one cycle. core_rst_no = '0 for all cores. Next state RECOVER, with counter loaded to RECOVERY_CYCLES-1.
- RECOVER: counter decrements each cycle. At 0, go to WAIT_DONE with counter loaded to TIMEOUT_CYCLES-1. RECOVER lasts exactly RECOVERY_CYCLES cycles.
- WAIT_DONE:
  - recovery_done_i=1 goes to IDLE, loading the guard counter with GUARD_CYCLES. Done is accepted even in the first WAIT_DONE cycle.
  - If the counter reaches 0 without done, go to FATAL.
- FATAL: sticky. core_rst_no = '0, recovering_o = 0 and load_pc_o = 0. clear_fatal_i goes to IDLE, clearing retry_cnt, faulty_core_o and the guard counter.
- error_i and force_error_i are ignored outside IDLE. A pulse during recovery is lost by design; the comparator holds error.
- enable_i = 0 in any state freezes everything, including counters. FATAL exit via clear_fatal_i also requires enable_i.

## Timing
- Reset values:
  - state IDLE, counters 0;
  - core_rst_no all 1s, recover_o 0, recovering_o 0, load_pc_o 1;
  - faulty_core_o 0, retry_cnt_o 0, fatal_o 0.
- Latency from an error sampled at edge k:
  - RESET is visible after edge k;
  - RECOVER spans edges k+1 to k+RECOVERY_CYCLES;
  - WAIT_DONE starts after edge k+1+RECOVERY_CYCLES.
- Minimum error-to-IDLE time is RECOVERY_CYCLES+2 cycles.
- Reset asserted mid-operation returns to the reset values immediately and asynchronously. No partial recovery is remembered.
- Error and guard expiry in the same cycle: the guard is evaluated before the decrement, so a counter value of 1 still counts as inside the window.

## Structure
- ft_pkg holds the ft_state_e enum (3-bit encoding) and the default parameter constants. It is shared with the comparator and the checkpoint unit.
- There are no sub-modules. A single CNT_W down-counter serves RECOVER, WAIT_DONE and the guard window, because they are mutually exclusive by state.

## Test plan
- Single fault: error_i=3'b010 for one cycle in IDLE.
  - Next: RESET with core_rst_no=3'b000 for 1 cycle, then recover_o high for 4 cycles, then WAIT_DONE.
  - After done: IDLE with faulty_core_o=3'b010 and retry_cnt_o=1.
- Retry escalation: 4 errors, each arriving fewer than 16 cycles after returning to IDLE.
  - retry_cnt_o goes 1→2→3, then fatal_o=1 on the 4th error.
  - clear_fatal_i returns to IDLE with retry_cnt_o=0.
- Guard expiry: a second error arriving 20 cycles after IDLE leaves retry_cnt_o=1, not 2.
- Timeout: recovery_done_i held low leads to FATAL exactly 64 cycles after entering WAIT_DONE.
- Freeze/reset: enable_i=0 for 10 cycles mid-RECOVER keeps recover_o high and the total RECOVER length at 4 enabled cycles. rst_ni low mid-WAIT_DONE gives the reset values in the same cycle.
- force_error_i alone: the full sequence runs with faulty_core_o=0.
